// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU opcode encodings and the multiply sequencer state encoding.
package alu_mul_seq_pkg;

    typedef enum logic [3:0] {
        ALU_ROL = 4'h0,
        ALU_SLL = 4'h1,
        ALU_ROR = 4'h2,
        ALU_SRL = 4'h3,
        ALU_ADD = 4'h4,
        ALU_OR  = 4'h5,
        ALU_XOR = 4'h6,
        ALU_AND = 4'h7,
        ALU_SEQ = 4'h8,
        ALU_SLT = 4'h9,
        ALU_SLE = 4'hA,
        ALU_SCO = 4'hB,
        ALU_BTR = 4'hC
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_SHL,
        ST_SHR,
        ST_DONE
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Port group between the multiply sequencer (master) and the shared execute-stage ALU (slave).
interface alu_mul_seq_if;
    logic [15:0] alu_A;
    logic [15:0] alu_B;
    logic [3:0]  alu_Op;
    logic        alu_Cin;
    logic        alu_invA;
    logic        alu_invB;
    logic        alu_sign;
    logic [15:0] alu_Out;
    logic        alu_Ofl;

    modport master (
        output alu_A, alu_B, alu_Op, alu_Cin, alu_invA, alu_invB, alu_sign,
        input  alu_Out, alu_Ofl
    );

    modport slave (
        input  alu_A, alu_B, alu_Op, alu_Cin, alu_invA, alu_invB, alu_sign,
        output alu_Out, alu_Ofl
    );
endinterface

// File: rtl/alu_mul_seq_fsm.sv
// Sequencer control: state, iteration counter and registered busy/done.
module alu_mul_seq_fsm
    import alu_mul_seq_pkg::*;
#(
    parameter int unsigned ITERS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    output mul_state_e state_o,
    output logic       last_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [4:0] LAST_CNT = 5'(ITERS - 1);

    mul_state_e state_q;
    logic [4:0] cnt_q;
    logic       busy_q;
    logic       done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_ADD;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ADD: state_q <= ST_SHL;
                ST_SHL: state_q <= ST_SHR;
                ST_SHR: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_ADD;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign last_o  = (cnt_q == LAST_CNT);
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add 16x16 unsigned multiply that borrows the execute-stage ALU one op per cycle.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int unsigned ITERS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [15:0]  op_a,
    input  logic [15:0]  op_b,
    output logic         busy,
    output logic         done,
    output logic [15:0]  product,
    output logic         ovf,
    alu_mul_seq_if.master alu
);

    mul_state_e  state;
    logic        last;

    logic [15:0] acc_q, acc_d;
    logic [15:0] mc_q, mc_d;
    logic [15:0] mp_q, mp_d;
    logic        ovf_r_q, ovf_r_d;
    logic [15:0] product_q, product_d;
    logic        ovf_q, ovf_d;

    alu_mul_seq_fsm #(.ITERS(ITERS)) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .state_o (state),
        .last_o  (last),
        .busy_o  (busy),
        .done_o  (done)
    );

    always_comb begin
        acc_d      = acc_q;
        mc_d       = mc_q;
        mp_d       = mp_q;
        ovf_r_d    = ovf_r_q;
        product_d  = product_q;
        ovf_d      = ovf_q;
        alu.alu_A  = '0;
        alu.alu_B  = '0;
        alu.alu_Op = ALU_ADD;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    mc_d    = op_a;
                    mp_d    = op_b;
                    acc_d   = '0;
                    ovf_r_d = 1'b0;
                end
            end
            ST_ADD: begin
                alu.alu_A = acc_q;
                alu.alu_B = mp_q[0] ? mc_q : '0;
                acc_d     = alu.alu_Out;
                ovf_r_d   = ovf_r_q | alu.alu_Ofl;
            end
            ST_SHL: begin
                alu.alu_A  = mc_q;
                alu.alu_B  = 16'h0001;
                alu.alu_Op = ALU_SLL;
                mc_d       = alu.alu_Out;
                // A multiplicand bit falls off while a higher multiplier bit still needs it.
                if (mc_q[15] && (mp_q[15:1] != '0)) ovf_r_d = 1'b1;
            end
            ST_SHR: begin
                alu.alu_A  = mp_q;
                alu.alu_B  = 16'h0001;
                alu.alu_Op = ALU_SRL;
                mp_d       = alu.alu_Out;
                if (last) begin
                    product_d = acc_q;
                    ovf_d     = ovf_r_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            mc_q      <= '0;
            mp_q      <= '0;
            ovf_r_q   <= 1'b0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            mc_q      <= mc_d;
            mp_q      <= mp_d;
            ovf_r_q   <= ovf_r_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    assign alu.alu_Cin  = 1'b0;
    assign alu.alu_invA = 1'b0;
    assign alu.alu_invB = 1'b0;
    assign alu.alu_sign = 1'b0;
    assign product      = product_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with an attached behavioural ALU and a multiply reference model.
module tb_alu_mul_seq;

    localparam int unsigned ITERS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        busy, done, ovf;
    logic [15:0] product;

    logic        start4 = 1'b0;
    logic [15:0] op_a4 = '0;
    logic [15:0] op_b4 = '0;
    logic        busy4, done4, ovf4;
    logic [15:0] product4;

    int unsigned checks = 0;
    int unsigned errors = 0;

    alu_mul_seq_if bus ();
    alu_mul_seq_if bus4 ();

    always #5 clk = ~clk;

    alu_mul_seq #(.ITERS(ITERS)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .product(product), .ovf(ovf), .alu(bus)
    );

    alu_mul_seq #(.ITERS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op_a(op_a4), .op_b(op_b4),
        .busy(busy4), .done(done4), .product(product4), .ovf(ovf4), .alu(bus4)
    );

    // Behavioural ALU: ADD reports carry-out on Ofl; shifts by B[3:0].
    function automatic logic [16:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'h4:    return {1'b0, a} + {1'b0, b};
            4'h1:    return {1'b0, a << b[3:0]};
            4'h3:    return {1'b0, a >> b[3:0]};
            default: return '0;
        endcase
    endfunction

    always_comb {bus.alu_Ofl, bus.alu_Out}   = alu_ref(bus.alu_Op, bus.alu_A, bus.alu_B);
    always_comb {bus4.alu_Ofl, bus4.alu_Out} = alu_ref(bus4.alu_Op, bus4.alu_A, bus4.alu_B);

    // Reference: {overflow, low 16 bits} of the true unsigned product.
    function automatic logic [16:0] mul_ref(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        return {(p[31:16] != '0), p[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one operation from IDLE and check latency, ALU op sequence, result and pulse width.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_p, input logic exp_o, input string tag);
        int unsigned n;
        int unsigned k;
        logic [3:0]  eop;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
        chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
        n = 1;
        while (!done && n < 200) begin
            k   = n - 1;
            eop = (k % 3 == 0) ? 4'h4 : ((k % 3 == 1) ? 4'h1 : 4'h3);
            chk({tag, " alu_Op"}, 32'(bus.alu_Op), 32'(eop));
            if (k % 3 == 0 && b == '0) chk({tag, " alu_B_add_zero"}, 32'(bus.alu_B), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, n, 3 * ITERS + 1);
        chk({tag, " product"}, 32'(product), 32'(exp_p));
        chk({tag, " ovf"}, 32'(ovf), 32'(exp_o));
        @(posedge clk); #1;
        chk({tag, " done_busy_after"}, {30'd0, done, busy}, 32'd0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        logic        o;
    } vec_t;

    initial begin
        vec_t        vecs[5];
        logic [16:0] r;
        logic [15:0] cap_a[$];
        logic [15:0] cap_b[$];
        logic [15:0] first_p;
        logic        prev_busy;
        int unsigned cyc, ndone, first_done_cyc, n;

        vecs[0] = '{16'h0003, 16'h0005, 16'h000F, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0001, 1'b1};
        vecs[2] = '{16'h0100, 16'h0100, 16'h0000, 1'b1};
        vecs[3] = '{16'h00FF, 16'h0101, 16'hFFFF, 1'b0};
        vecs[4] = '{16'h1234, 16'h0000, 16'h0000, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset product", 32'(product), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        chk("reset alu_Op", 32'(bus.alu_Op), 32'h4);
        chk("reset alu_consts", {28'd0, bus.alu_Cin, bus.alu_invA, bus.alu_invB, bus.alu_sign}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].o, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d hold_idle", i), 32'(product), 32'(vecs[i].p));
        end

        for (int i = 0; i < 30; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = (i % 3 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            r = mul_ref(a, b);
            run_op(a, b, r[15:0], r[16], $sformatf("rand%0d", i));
        end

        // start held high with operands changing every cycle
        prev_busy = 1'b0;
        cyc = 0;
        ndone = 0;
        first_done_cyc = 0;
        first_p = '0;
        while (ndone < 2 && cyc < 300) begin
            op_a  = 16'($urandom);
            op_b  = 16'($urandom);
            start = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (!prev_busy && busy) begin
                if (ndone == 1) chk("held product_hold", 32'(product), 32'(first_p));
                cap_a.push_back(op_a);
                cap_b.push_back(op_b);
            end
            if (done && cap_a.size() > 0) begin
                r = mul_ref(cap_a.pop_front(), cap_b.pop_front());
                chk($sformatf("held product%0d", ndone), 32'(product), 32'(r[15:0]));
                chk($sformatf("held ovf%0d", ndone), 32'(ovf), 32'(r[16]));
                if (ndone == 0) begin
                    first_done_cyc = cyc;
                    first_p = product;
                end else begin
                    chk("held done_spacing", cyc - first_done_cyc, 32'd50);
                end
                ndone++;
            end
            prev_busy = busy;
        end
        start = 1'b0;
        chk("held done_count", ndone, 32'd2);
        @(posedge clk); #1;

        // reset in the middle of an operation
        run_op(16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, "pre_reset");
        op_a  = 16'h00FF;
        op_b  = 16'h0101;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("midrun busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst product", 32'(product), 32'd0);
        chk("midrst ovf", 32'(ovf), 32'd0);
        chk("midrst idle_alu", {bus.alu_Op, bus.alu_A, 12'd0}, {4'h4, 16'h0000, 12'd0});
        chk("midrst idle_aluB", 32'(bus.alu_B), 32'd0);
        run_op(16'h0003, 16'h0005, 16'h000F, 1'b0, "post_reset");

        // four-iteration build: upper multiplier bits ignored
        op_a4  = 16'h0007;
        op_b4  = 16'h00F3;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        n = 1;
        while (!done4 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("iters4 latency", n, 32'd13);
        chk("iters4 product", 32'(product4), 32'd21);
        chk("iters4 ovf", 32'(ovf4), 32'd0);
        @(posedge clk); #1;
        chk("iters4 done_pulse", 32'(done4), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
